id_stage: RTL

//  Instruction-decode stage of the 5-stage ARM-subset pipeline, directly downstream of instruction fetch.

---
 rtl/arm_defs_pkg.sv | 99 +++++++++
 rtl/id_stage_if.sv | 42 ++++
 rtl/register_file.sv | 35 +++
 rtl/id_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arm_defs_pkg.sv
// Shared ARM-subset encodings: ALU commands, opcodes, condition codes, modes and the
// control bundle carried across the ID/EX boundary.
package arm_defs_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_MEM = 4'b0100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
  } id_data_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // nzcv is {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID inputs, write-back port, hazard-unit taps and ID/EX outputs of the decode stage.
interface id_stage_if;
  logic [31:0] pc_in;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic        hazard;
  logic        freeze;
  logic        flush;
  logic        wb_en_in;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;

  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;

  logic [31:0] pc_out;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        b;
  logic        s;
  logic [3:0]  exe_cmd;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;

  modport master (
    output pc_in, instruction, status, hazard, freeze, flush, wb_en_in, wb_dest, wb_value,
    input  src1, src2, two_src, pc_out, val_rn, val_rm, wb_en, mem_r_en, mem_w_en, b, s,
    input  exe_cmd, imm, shift_operand, signed_imm_24, dest
  );

  modport slave (
    input  pc_in, instruction, status, hazard, freeze, flush, wb_en_in, wb_dest, wb_value,
    output src1, src2, two_src, pc_out, val_rn, val_rm, wb_en, mem_r_en, mem_w_en, b, s,
    output exe_cmd, imm, shift_operand, signed_imm_24, dest
  );
endinterface

// File: rtl/register_file.sv
// N_REGS x 32 register file: two combinational read ports with write-through, one write port,
// asynchronously cleared.
module register_file #(
  parameter int unsigned N_REGS = 16,
  localparam int unsigned AW = $clog2(N_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [31:0]   rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output logic [31:0]   rdata2_o
);

  logic [31:0] regs_q [N_REGS];
  logic [31:0] regs_d [N_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Write-through lets decode see a value retiring in the same cycle.
  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// Decode stage: field decode, NZCV condition check and operand read, registered into ID/EX.
// flush beats freeze beats a normal load; the register file writes regardless of freeze.
module id_stage
  import arm_defs_pkg::*;
#(
  parameter int unsigned N_REGS = 16
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  logic [3:0] cond, opcode, rn, rd, rm;
  logic [1:0] mode;
  logic       i_bit, s_bit, is_str;
  logic [31:0] rn_val, rm_val;

  ctrl_t    ctrl_dec, ctrl_issue, ctrl_d, ctrl_q;
  id_data_t data_new, data_d, data_q;

  assign cond   = bus.instruction[31:28];
  assign mode   = bus.instruction[27:26];
  assign i_bit  = bus.instruction[25];
  assign opcode = bus.instruction[24:21];
  assign s_bit  = bus.instruction[20];
  assign rn     = bus.instruction[19:16];
  assign rd     = bus.instruction[15:12];
  assign rm     = bus.instruction[3:0];

  assign is_str = (mode == MODE_MEM) && (opcode == OP_MEM) && !s_bit;

  assign bus.src1    = rn;
  assign bus.src2    = is_str ? rd : rm;
  assign bus.two_src = ~i_bit | is_str;

  register_file #(
    .N_REGS (N_REGS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (bus.wb_en_in),
    .waddr_i  (bus.wb_dest),
    .wdata_i  (bus.wb_value),
    .raddr1_i (bus.src1),
    .rdata1_o (rn_val),
    .raddr2_i (bus.src2),
    .rdata2_o (rm_val)
  );

  always_comb begin
    ctrl_dec = CTRL_BUBBLE;
    case (mode)
      MODE_DP: begin
        ctrl_dec.s     = s_bit;
        ctrl_dec.wb_en = 1'b1;
        case (opcode)
          OP_MOV: ctrl_dec.exe_cmd = EXE_MOV;
          OP_MVN: ctrl_dec.exe_cmd = EXE_MVN;
          OP_ADD: ctrl_dec.exe_cmd = EXE_ADD;
          OP_ADC: ctrl_dec.exe_cmd = EXE_ADC;
          OP_SUB: ctrl_dec.exe_cmd = EXE_SUB;
          OP_SBC: ctrl_dec.exe_cmd = EXE_SBC;
          OP_AND: ctrl_dec.exe_cmd = EXE_AND;
          OP_ORR: ctrl_dec.exe_cmd = EXE_ORR;
          OP_EOR: ctrl_dec.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl_dec.exe_cmd = EXE_SUB;
            ctrl_dec.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl_dec.exe_cmd = EXE_AND;
            ctrl_dec.wb_en   = 1'b0;
          end
          default: ctrl_dec = CTRL_BUBBLE;
        endcase
      end
      MODE_MEM: begin
        if (opcode == OP_MEM) begin
          ctrl_dec.exe_cmd = EXE_ADD;
          if (s_bit) begin
            ctrl_dec.mem_r_en = 1'b1;
            ctrl_dec.wb_en    = 1'b1;
          end else begin
            ctrl_dec.mem_w_en = 1'b1;
          end
        end
      end
      MODE_BR: ctrl_dec.b = 1'b1;
      default: ctrl_dec = CTRL_BUBBLE;
    endcase
  end

  assign ctrl_issue = (cond_pass(cond, bus.status) && !bus.hazard) ? ctrl_dec : CTRL_BUBBLE;

  always_comb begin
    data_new.pc            = bus.pc_in;
    data_new.val_rn        = rn_val;
    data_new.val_rm        = rm_val;
    data_new.imm           = i_bit;
    data_new.shift_operand = bus.instruction[11:0];
    data_new.signed_imm_24 = bus.instruction[23:0];
    data_new.dest          = rd;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (bus.flush) begin
      ctrl_d = CTRL_BUBBLE;
      data_d = data_new;
    end else if (!bus.freeze) begin
      ctrl_d = ctrl_issue;
      data_d = data_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_BUBBLE;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign bus.pc_out        = data_q.pc;
  assign bus.val_rn        = data_q.val_rn;
  assign bus.val_rm        = data_q.val_rm;
  assign bus.imm           = data_q.imm;
  assign bus.shift_operand = data_q.shift_operand;
  assign bus.signed_imm_24 = data_q.signed_imm_24;
  assign bus.dest          = data_q.dest;
  assign bus.wb_en         = ctrl_q.wb_en;
  assign bus.mem_r_en      = ctrl_q.mem_r_en;
  assign bus.mem_w_en      = ctrl_q.mem_w_en;
  assign bus.b             = ctrl_q.b;
  assign bus.s             = ctrl_q.s;
  assign bus.exe_cmd       = ctrl_q.exe_cmd;

endmodule
